instruction_loader: RTL and testbench

Write-side companion of the instruction memory. Receives the program as a byte stream (from the debug/UART path) and packs each group of four bytes, most significant byte first, into a 32-bit instruction. It then drives the instruction memory write port at byte addresses 0, 4, 8, … until the halt word (all ones) has been written or the memory is full. The block sits between the debug unit's byte receiver and the instruction memory, and is active only while the processor is held out of execution.

---
 rtl/instruction_loader_pkg.sv | 16 +
 rtl/instruction_loader_word_assembler.sv | 45 ++++
 rtl/instruction_loader.sv | 129 ++++++++++++
 tb/tb_instruction_loader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the instruction loader: FSM encoding, halt word, word geometry.
// Pure declarations; no logic or timing of its own.
package instruction_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RECEIVE = 2'd1,
      ST_WRITE   = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam logic [31:0] HALT_WORD      = 32'hFFFF_FFFF;
   localparam int          BYTES_PER_WORD = 4;
   localparam int          ADDR_STEP      = 4;

endpackage

// File: rtl/instruction_loader_word_assembler.sv
// Packs bytes MSB-first into a word; word_rdy is combinational with the 4th accepted byte (0 cycles).
// No backpressure: one byte per cycle whenever byte_vld is high; clear has priority and drops a partial word.
module instruction_loader_word_assembler
   import instruction_loader_pkg::*;
#(
   parameter int NBITS = 32,
   parameter int NBYTE = 8
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             clear,
   input  logic             byte_vld,
   input  logic [NBYTE-1:0] byte_dat,
   output logic [NBITS-1:0] word_dat,
   output logic             word_rdy
);

   localparam int PACK_W = NBITS - NBYTE;

   logic [1:0]        byte_cnt;
   logic [PACK_W-1:0] pack_q;
   logic              last_byte;

   assign last_byte = (byte_cnt == 2'(BYTES_PER_WORD - 1));
   assign word_rdy  = byte_vld && last_byte && !clear;
   // The first three bytes have shifted up to the top of pack_q by the time the 4th arrives.
   assign word_dat  = {pack_q, byte_dat};

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         byte_cnt <= '0;
         pack_q   <= '0;
      end else if (clear) begin
         byte_cnt <= '0;
         pack_q   <= '0;
      end else if (byte_vld) begin
         byte_cnt <= byte_cnt + 2'd1;
         if (last_byte)
            pack_q <= '0;
         else
            pack_q <= {pack_q[PACK_W-NBYTE-1:0], byte_dat};
      end
   end

endmodule

// File: rtl/instruction_loader.sv
// Byte stream to instruction memory writer; write strobe in the cycle after the 4th byte. Optional LOADER_HALT_DETECT_EN.
// No backpressure: accepts 1 byte/cycle in RECEIVE and WRITE, ignores bytes in IDLE and DONE.
module instruction_loader
   import instruction_loader_pkg::*;
#(
   parameter int NBITS  = 32,
   parameter int NBYTE  = 8,
   parameter int CELDAS = 60
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_Start,
   input  logic [NBYTE-1:0] i_Byte,
   input  logic             i_Byte_Valid,
   output logic             o_Write_Enable,
   output logic [NBITS-1:0] o_Address,
   output logic [NBITS-1:0] o_Instruction,
   output logic [NBITS-1:0] o_Word_Count,
   output logic             o_Busy,
   output logic             o_Done,
   output logic             o_Error
);

`ifdef LOADER_HALT_DETECT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   localparam logic [NBITS-1:0] STEP      = NBITS'(ADDR_STEP);
   localparam logic [NBITS-1:0] LAST_ADDR = NBITS'(CELDAS - ADDR_STEP);

   state_t           state_q, state_d;
   logic             byte_acc;
   logic             word_rdy;
   logic [NBITS-1:0] word_dat;
   logic             is_halt;
   logic             mem_full;
   logic             to_done;
   logic             set_err;

   assign o_Write_Enable = (state_q == ST_WRITE);
   assign o_Busy         = (state_q == ST_RECEIVE) || (state_q == ST_WRITE);
   // A start pulse wins over a coincident byte: the load restarts from an empty word.
   assign byte_acc       = i_Byte_Valid && o_Busy && !i_Start;
   assign is_halt        = HALT_EN && (o_Instruction == NBITS'(HALT_WORD));
   assign mem_full       = (o_Address + STEP) > LAST_ADDR;

   instruction_loader_word_assembler #(
      .NBITS (NBITS),
      .NBYTE (NBYTE)
   ) u_word_assembler (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .clear    (i_Start),
      .byte_vld (byte_acc),
      .byte_dat (i_Byte),
      .word_dat (word_dat),
      .word_rdy (word_rdy)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      to_done = 1'b0;
      set_err = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_Start) state_d = ST_RECEIVE;
         end
         ST_RECEIVE: begin
            if (i_Start)       state_d = ST_RECEIVE;
            else if (word_rdy) state_d = ST_WRITE;
         end
         ST_WRITE: begin
            if (i_Start) begin
               state_d = ST_RECEIVE;
            end else if (is_halt) begin
               state_d = ST_DONE;
               to_done = 1'b1;
            end else if (mem_full) begin
               state_d = ST_DONE;
               to_done = 1'b1;
               set_err = HALT_EN;
            end else begin
               state_d = ST_RECEIVE;
            end
         end
         ST_DONE: begin
            if (i_Start) state_d = ST_RECEIVE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_Address     <= '0;
         o_Instruction <= '0;
         o_Word_Count  <= '0;
         o_Done        <= 1'b0;
         o_Error       <= 1'b0;
      end else if (i_Start) begin
         o_Address    <= '0;
         o_Word_Count <= '0;
         o_Done       <= 1'b0;
         o_Error      <= 1'b0;
      end else begin
         if (word_rdy)
            o_Instruction <= word_dat;
         if (state_q == ST_WRITE) begin
            o_Word_Count <= o_Word_Count + 1'b1;
            if (to_done) begin
               o_Done  <= 1'b1;
               o_Error <= set_err;
            end else begin
               o_Address <= o_Address + STEP;
            end
         end
      end
   end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: cycle table plus hand sequences for full memory, DONE/IDLE bytes and async reset.
// Expectations follow LOADER_HALT_DETECT_EN when it is defined for the build.
module tb_instruction_loader;

`ifdef LOADER_HALT_DETECT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        i_reset;
   logic        i_Start;
   logic [7:0]  i_Byte;
   logic        i_Byte_Valid;
   logic        o_Write_Enable;
   logic [31:0] o_Address;
   logic [31:0] o_Instruction;
   logic [31:0] o_Word_Count;
   logic        o_Busy;
   logic        o_Done;
   logic        o_Error;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      logic        start;
      logic        vld;
      logic [7:0]  dat;
      logic [31:0] we;
      logic [31:0] addr;
      logic [31:0] instr;
      logic [31:0] cnt;
      logic [31:0] busy;
      logic [31:0] done;
      logic [31:0] err;
   } vec_t;

   vec_t vec_q[$];

   always #5 clk = ~clk;

   instruction_loader #(.NBITS(32), .NBYTE(8), .CELDAS(60)) dut (
      .i_clk          (clk),
      .i_reset        (i_reset),
      .i_Start        (i_Start),
      .i_Byte         (i_Byte),
      .i_Byte_Valid   (i_Byte_Valid),
      .o_Write_Enable (o_Write_Enable),
      .o_Address      (o_Address),
      .o_Instruction  (o_Instruction),
      .o_Word_Count   (o_Word_Count),
      .o_Busy         (o_Busy),
      .o_Done         (o_Done),
      .o_Error        (o_Error)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic [31:0] s, input logic [31:0] v, input logic [31:0] d,
                      input logic [31:0] we, input logic [31:0] addr, input logic [31:0] instr,
                      input logic [31:0] cnt, input logic [31:0] busy, input logic [31:0] done,
                      input logic [31:0] err);
      vec_t r;
      r.start = s[0];
      r.vld   = v[0];
      r.dat   = d[7:0];
      r.we    = we;
      r.addr  = addr;
      r.instr = instr;
      r.cnt   = cnt;
      r.busy  = busy;
      r.done  = done;
      r.err   = err;
      vec_q.push_back(r);
   endtask

   task automatic step(input logic [31:0] s, input logic [31:0] v, input logic [31:0] d);
      i_Start      = s[0];
      i_Byte_Valid = v[0];
      i_Byte       = d[7:0];
      @(posedge clk);
      #1;
      i_Start      = 1'b0;
      i_Byte_Valid = 1'b0;
   endtask

   task automatic reset_dut();
      i_reset = 1'b1;
      #3;
      i_reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      i_reset      = 1'b1;
      i_Start      = 1'b0;
      i_Byte       = 8'h00;
      i_Byte_Valid = 1'b0;
      #2;
      chk("reset we",    32'(o_Write_Enable), 32'd0);
      chk("reset addr",  o_Address,           32'd0);
      chk("reset instr", o_Instruction,       32'd0);
      chk("reset cnt",   o_Word_Count,        32'd0);
      chk("reset busy",  32'(o_Busy),         32'd0);
      chk("reset done",  32'(o_Done),         32'd0);
      chk("reset err",   32'(o_Error),        32'd0);
      #1;
      i_reset = 1'b0;

      // Load then halt: start, 80 22 00 02, FF x4 (first FF lands in the WRITE cycle)
      add(1, 0, 'h00, 0, 0, 'h0,        0, 1, 0, 0);
      add(0, 1, 'h80, 0, 0, 'h0,        0, 1, 0, 0);
      add(0, 1, 'h22, 0, 0, 'h0,        0, 1, 0, 0);
      add(0, 1, 'h00, 0, 0, 'h0,        0, 1, 0, 0);
      add(0, 1, 'h02, 1, 0, 'h80220002, 0, 1, 0, 0);
      add(0, 1, 'hFF, 0, 4, 'h80220002, 1, 1, 0, 0);
      add(0, 1, 'hFF, 0, 4, 'h80220002, 1, 1, 0, 0);
      add(0, 1, 'hFF, 0, 4, 'h80220002, 1, 1, 0, 0);
      add(0, 1, 'hFF, 1, 4, 'hFFFFFFFF, 1, 1, 0, 0);
      if (HALT_EN) add(0, 0, 'h00, 0, 4, 'hFFFFFFFF, 2, 0, 1, 0);
      else         add(0, 0, 'h00, 0, 8, 'hFFFFFFFF, 2, 1, 0, 0);
      // Back-to-back bytes 00 00 00 01 00 00 00 02
      add(1, 0, 'h00, 0, 0, 'hFFFFFFFF, 0, 1, 0, 0);
      add(0, 1, 'h00, 0, 0, 'hFFFFFFFF, 0, 1, 0, 0);
      add(0, 1, 'h00, 0, 0, 'hFFFFFFFF, 0, 1, 0, 0);
      add(0, 1, 'h00, 0, 0, 'hFFFFFFFF, 0, 1, 0, 0);
      add(0, 1, 'h01, 1, 0, 'h00000001, 0, 1, 0, 0);
      add(0, 1, 'h00, 0, 4, 'h00000001, 1, 1, 0, 0);
      add(0, 1, 'h00, 0, 4, 'h00000001, 1, 1, 0, 0);
      add(0, 1, 'h00, 0, 4, 'h00000001, 1, 1, 0, 0);
      add(0, 1, 'h02, 1, 4, 'h00000002, 1, 1, 0, 0);
      add(0, 0, 'h00, 0, 8, 'h00000002, 2, 1, 0, 0);
      // Restart after a partial word
      add(0, 1, 'hAA, 0, 8, 'h00000002, 2, 1, 0, 0);
      add(0, 1, 'hBB, 0, 8, 'h00000002, 2, 1, 0, 0);
      add(1, 0, 'h00, 0, 0, 'h00000002, 0, 1, 0, 0);
      add(0, 1, 'h11, 0, 0, 'h00000002, 0, 1, 0, 0);
      add(0, 1, 'h22, 0, 0, 'h00000002, 0, 1, 0, 0);
      add(0, 1, 'h33, 0, 0, 'h00000002, 0, 1, 0, 0);
      add(0, 1, 'h44, 1, 0, 'h11223344, 0, 1, 0, 0);
      add(0, 0, 'h00, 0, 4, 'h11223344, 1, 1, 0, 0);

      for (int i = 0; i < vec_q.size(); i++) begin
         step(32'(vec_q[i].start), 32'(vec_q[i].vld), 32'(vec_q[i].dat));
         chk($sformatf("row%0d we", i),    32'(o_Write_Enable), vec_q[i].we);
         chk($sformatf("row%0d addr", i),  o_Address,           vec_q[i].addr);
         chk($sformatf("row%0d instr", i), o_Instruction,       vec_q[i].instr);
         chk($sformatf("row%0d cnt", i),   o_Word_Count,        vec_q[i].cnt);
         chk($sformatf("row%0d busy", i),  32'(o_Busy),         vec_q[i].busy);
         chk($sformatf("row%0d done", i),  32'(o_Done),         vec_q[i].done);
         chk($sformatf("row%0d err", i),   32'(o_Error),        vec_q[i].err);
      end

      // Bytes in IDLE are ignored
      reset_dut();
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 32'h10 + 32'(i));
         chk($sformatf("idle%0d we", i),   32'(o_Write_Enable), 32'd0);
         chk($sformatf("idle%0d busy", i), 32'(o_Busy),         32'd0);
         chk($sformatf("idle%0d cnt", i),  o_Word_Count,        32'd0);
      end

      // Memory full: 15 non-halt words, bytes streamed without gaps
      step(1, 0, 0);
      for (int w = 0; w < 15; w++) begin
         for (int b = 0; b < 4; b++) begin
            logic [7:0] bv;
            case (b)
               0:       bv = 8'(w);
               1:       bv = 8'hA5;
               2:       bv = 8'h5A;
               default: bv = 8'(w + 1);
            endcase
            step(0, 1, 32'(bv));
         end
         chk($sformatf("full w%0d we", w),    32'(o_Write_Enable), 32'd1);
         chk($sformatf("full w%0d addr", w),  o_Address,           32'(4 * w));
         chk($sformatf("full w%0d instr", w), o_Instruction,
             {8'(w), 8'hA5, 8'h5A, 8'(w + 1)});
      end
      step(0, 0, 0);
      chk("full done", 32'(o_Done),         32'd1);
      chk("full err",  32'(o_Error),        32'(HALT_EN));
      chk("full busy", 32'(o_Busy),         32'd0);
      chk("full cnt",  o_Word_Count,        32'd15);
      chk("full addr", o_Address,           32'd56);
      chk("full we",   32'(o_Write_Enable), 32'd0);

      // Bytes in DONE are ignored
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 32'hC0 + 32'(i));
         chk($sformatf("donebyte%0d we", i),   32'(o_Write_Enable), 32'd0);
         chk($sformatf("donebyte%0d cnt", i),  o_Word_Count,        32'd15);
         chk($sformatf("donebyte%0d done", i), 32'(o_Done),         32'd1);
      end

      // Async reset in the middle of the second WRITE cycle
      step(1, 0, 0);
      step(0, 1, 'h01); step(0, 1, 'h02); step(0, 1, 'h03); step(0, 1, 'h04);
      step(0, 1, 'h05); step(0, 1, 'h06); step(0, 1, 'h07); step(0, 1, 'h08);
      chk("pre-rst we",    32'(o_Write_Enable), 32'd1);
      chk("pre-rst addr",  o_Address,           32'd4);
      chk("pre-rst instr", o_Instruction,       32'h05060708);
      #2;
      i_reset = 1'b1;
      #1;
      chk("arst we",    32'(o_Write_Enable), 32'd0);
      chk("arst addr",  o_Address,           32'd0);
      chk("arst instr", o_Instruction,       32'd0);
      chk("arst cnt",   o_Word_Count,        32'd0);
      chk("arst busy",  32'(o_Busy),         32'd0);
      chk("arst done",  32'(o_Done),         32'd0);
      #1;
      i_reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 32'h21 + 32'(i));
         chk($sformatf("post-rst%0d we", i),   32'(o_Write_Enable), 32'd0);
         chk($sformatf("post-rst%0d busy", i), 32'(o_Busy),         32'd0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
